// File: rtl/prescaled_updown_counter.sv
// Modulo-MOD up/down counter stepped by an on-clock prescaler enable.
// Supports synchronous load, wrap or saturate, and tick/terminal-count pulses.
module prescaled_updown_counter #(
    parameter int WIDTH = 4,
    parameter int MOD   = 16,
    parameter int PW    = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [PW-1:0]    div,
    output logic [WIDTH-1:0] s,
    output logic             tick,
    output logic             tc,
    output logic             at_lim
);

    // Count arithmetic is one bit wider so MOD == 2**WIDTH cannot overflow.
    localparam int               LIM_I   = MOD - 1;
    localparam logic [WIDTH:0]   LIM     = LIM_I[WIDTH:0];
    localparam logic [WIDTH:0]   ONE     = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [PW-1:0]    PRE_ONE = {{(PW-1){1'b0}}, 1'b1};

    logic [PW-1:0]    pre_q, pre_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             tick_q, tick_d;
    logic             tc_q, tc_d;
    logic             step;
    logic [WIDTH:0]   s_ext, s_inc, s_dec, ld_ext;

    assign s_ext  = {1'b0, s_q};
    assign s_inc  = s_ext + ONE;
    assign s_dec  = s_ext - ONE;
    assign ld_ext = {1'b0, load_val};
    // >= rather than == so lowering div below pre rolls over at once.
    assign step   = en && !load && (pre_q >= div);

    always_comb begin
        pre_d  = pre_q;
        s_d    = s_q;
        tick_d = 1'b0;
        tc_d   = 1'b0;
        if (load) begin
            pre_d = '0;
            s_d   = (ld_ext >= LIM) ? LIM[WIDTH-1:0] : load_val;
        end else if (en) begin
            tick_d = step;
            if (step) begin
                pre_d = '0;
                if (dir) begin
                    if (s_ext < LIM) begin
                        s_d  = s_inc[WIDTH-1:0];
                        tc_d = sat && (s_inc == LIM);
                    end else if (!sat) begin
                        s_d  = '0;
                        tc_d = 1'b1;
                    end
                end else begin
                    if (s_ext != '0) begin
                        s_d  = s_dec[WIDTH-1:0];
                        tc_d = sat && (s_dec == '0);
                    end else if (!sat) begin
                        s_d  = LIM[WIDTH-1:0];
                        tc_d = 1'b1;
                    end
                end
            end else begin
                pre_d = pre_q + PRE_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q  <= '0;
            s_q    <= '0;
            tick_q <= 1'b0;
            tc_q   <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            s_q    <= s_d;
            tick_q <= tick_d;
            tc_q   <= tc_d;
        end
    end

    assign s      = s_q;
    assign tick   = tick_q;
    assign tc     = tc_q;
    assign at_lim = dir ? (s_ext == LIM) : (s_q == '0);

endmodule

// File: tb/tb_prescaled_updown_counter.sv
// Directed bench for prescaled_updown_counter (WIDTH=4, MOD=10) with a
// cycle scoreboard plus fixed-value checks at the interesting points.
module tb_prescaled_updown_counter;

    localparam int WIDTH = 4;
    localparam int MOD   = 10;
    localparam int PW    = 8;
    localparam int EW    = WIDTH + 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             dir;
    logic             sat;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [PW-1:0]    div;
    logic [WIDTH-1:0] s;
    logic             tick;
    logic             tc;
    logic             at_lim;

    prescaled_updown_counter #(.WIDTH(WIDTH), .MOD(MOD), .PW(PW)) dut (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .sat(sat), .load(load),
        .load_val(load_val), .div(div), .s(s), .tick(tick), .tc(tc),
        .at_lim(at_lim)
    );

    always #5 clk = ~clk;

    // Reference state, advanced once per posedge from the current inputs.
    int m_pre, m_s;
    bit m_tick, m_tc;

    logic [EW-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic model_reset();
        m_pre = 0; m_s = 0; m_tick = 0; m_tc = 0;
    endtask

    task automatic model_edge();
        bit stp;
        if (rst) begin
            model_reset();
        end else if (load) begin
            m_s   = (int'(load_val) >= MOD) ? MOD - 1 : int'(load_val);
            m_pre = 0; m_tick = 0; m_tc = 0;
        end else if (!en) begin
            m_tick = 0; m_tc = 0;
        end else begin
            stp    = (m_pre >= int'(div));
            m_tick = stp;
            m_tc   = 0;
            if (!stp) begin
                m_pre = m_pre + 1;
            end else begin
                m_pre = 0;
                if (dir) begin
                    if (m_s == MOD - 1) begin
                        if (!sat) begin m_s = 0; m_tc = 1; end
                    end else begin
                        m_s = m_s + 1;
                        if (sat && m_s == MOD - 1) m_tc = 1;
                    end
                end else begin
                    if (m_s == 0) begin
                        if (!sat) begin m_s = MOD - 1; m_tc = 1; end
                    end else begin
                        m_s = m_s - 1;
                        if (sat && m_s == 0) m_tc = 1;
                    end
                end
            end
        end
    endtask

    function automatic bit model_lim();
        return dir ? (m_s == MOD - 1) : (m_s == 0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: model pushes at posedge, DUT compared at the following negedge.
    task automatic cycle();
        logic [EW-1:0] e, o;
        @(posedge clk);
        model_edge();
        exp_q.push_back({WIDTH'(m_s), m_tick, m_tc, model_lim()});
        @(negedge clk);
        e = exp_q.pop_front();
        o = {s, tick, tc, at_lim};
        n_checks++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL scoreboard {s,tick,tc,at_lim} t=%0t: observed %h expected %h", $time, o, e);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Called at a negedge; rst rises between edges and is checked before the next edge.
    task automatic async_reset(input string tag);
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk({tag, "_s"}, 32'(s), 0);
        chk({tag, "_tick"}, 32'(tick), 0);
        chk({tag, "_tc"}, 32'(tc), 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int ticks, tcs;
        int en_pat[4];
        int s_pat[4];

        rst = 1'b1; en = 1'b0; dir = 1'b1; sat = 1'b0; load = 1'b0;
        load_val = '0; div = 8'd3;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("reset_s", 32'(s), 0);
        chk("reset_tick", 32'(tick), 0);
        chk("reset_tc", 32'(tc), 0);

        // Up count with wrap, div=3: one step every 4 clocks.
        rst = 1'b0; en = 1'b1;
        ticks = 0; tcs = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (i == 3) chk("first_step_s", 32'(s), 1);
            if (tick) ticks++;
            if (tc) tcs++;
        end
        chk("up_ticks", 32'(ticks), 10);
        chk("up_tc_once", 32'(tcs), 1);
        chk("up_wrap_s", 32'(s), 0);

        // Down count from reset wraps to MOD-1 with tc.
        async_reset("rst_dn");
        dir = 1'b0;
        cycles(4);
        chk("dn_first_s", 32'(s), 9);
        chk("dn_first_tc", 32'(tc), 1);
        cycles(4);
        chk("dn_second_s", 32'(s), 8);
        chk("dn_second_tc", 32'(tc), 0);

        // Saturating up count from a loaded value.
        sat = 1'b1; dir = 1'b1; load_val = 4'd7; load = 1'b1;
        cycle();
        load = 1'b0;
        chk("sat_load_s", 32'(s), 7);
        cycles(4);
        chk("sat_8_s", 32'(s), 8);
        chk("sat_8_tc", 32'(tc), 0);
        cycles(4);
        chk("sat_9_s", 32'(s), 9);
        chk("sat_9_tc", 32'(tc), 1);
        chk("sat_9_lim", 32'(at_lim), 1);
        cycles(4);
        chk("sat_hold_s", 32'(s), 9);
        chk("sat_hold_tick", 32'(tick), 1);
        chk("sat_hold_tc", 32'(tc), 0);

        // div=0 with en gating.
        sat = 1'b0; div = 8'd0; load_val = 4'd0; load = 1'b1;
        cycle();
        load = 1'b0;
        en_pat = '{1, 0, 1, 1};
        s_pat  = '{1, 1, 2, 3};
        for (int i = 0; i < 4; i++) begin
            en = en_pat[i][0];
            cycle();
            chk($sformatf("en_gate_%0d", i), 32'(s), 32'(s_pat[i]));
        end

        // Runtime decrease of div below the prescaler value.
        async_reset("rst_div");
        en = 1'b1; div = 8'd100;
        cycles(50);
        chk("div100_no_tick", 32'(tick), 0);
        div = 8'd10;
        cycle();
        chk("div_drop_tick", 32'(tick), 1);
        chk("div_drop_s", 32'(s), 1);
        ticks = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (tick) ticks++;
        end
        chk("div11_gap", 32'(ticks), 0);
        cycle();
        chk("div11_tick", 32'(tick), 1);
        chk("div11_s", 32'(s), 2);

        // Async reset mid-count while a tick is high.
        div = 8'd0; load_val = 4'd2; load = 1'b1;
        cycle();
        load = 1'b0;
        cycles(3);
        chk("pre_rst_s", 32'(s), 5);
        async_reset("rst_mid");

        // Load clamping with en low, then load beating a step.
        en = 1'b0; load_val = 4'd15; load = 1'b1;
        cycle();
        chk("clamp_s", 32'(s), 9);
        en = 1'b1; div = 8'd0; load_val = 4'd3; load = 1'b1;
        cycle();
        chk("load_wins_s", 32'(s), 3);
        chk("load_wins_tick", 32'(tick), 0);
        load = 1'b0;
        cycle();
        chk("after_load_s", 32'(s), 4);
        chk("after_load_tick", 32'(tick), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
